// File: rtl/ddr_eng_pkg.sv
// ---------------------------------------------------------------------------
// ddr_eng_pkg
// Shared types and constants for the DDR burst engine: FSM state encoding,
// command opcode encoding, status-word bit positions and a small helper for
// sizing beat indices.
// ---------------------------------------------------------------------------
package ddr_eng_pkg;

    typedef enum logic [2:0] {
        INIT     = 3'd0,
        IDLE     = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_DATA  = 3'd4
    } state_e;

    typedef enum logic {
        OP_STORE = 1'b0,
        OP_LOAD  = 1'b1
    } op_e;

    localparam int STAT_STATE_LSB    = 0;
    localparam int STAT_BUSY         = 3;
    localparam int STAT_DONE         = 4;
    localparam int STAT_TIMEOUT      = 5;
    localparam int STAT_LEN_ERR      = 6;
    localparam int STAT_BUF_CONFLICT = 7;
    localparam int STAT_BEATS_LSB    = 8;
    localparam int STAT_BEATS_W      = 8;

    // A single-entry buffer still needs a 1-bit index to keep ports legal.
    function automatic int beat_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ddr_beat_buffer.sv
// ---------------------------------------------------------------------------
// ddr_beat_buffer
// DEPTH x DATA_WIDTH beat storage with two access ports:
//   word port : 32-bit write (word_wr/word_idx/word_din) and registered read
//               (word_rd -> word_dout one cycle later). Word 0 is beat0[31:0].
//   beat port : combinational full-beat read at beat_idx, single-cycle full
//               beat write (beat_we/beat_wdata).
// Ports: clk, rst_n (async active-low, clears storage and word_dout).
// ---------------------------------------------------------------------------
module ddr_beat_buffer
    import ddr_eng_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     word_wr,
    input  logic                                     word_rd,
    input  logic [$clog2(DEPTH*DATA_WIDTH/32)-1:0]   word_idx,
    input  logic [31:0]                              word_din,
    output logic [31:0]                              word_dout,
    input  logic [beat_idx_width(DEPTH)-1:0]         beat_idx,
    output logic [DATA_WIDTH-1:0]                    beat_rdata,
    input  logic                                     beat_we,
    input  logic [DATA_WIDTH-1:0]                    beat_wdata
);

    localparam int WPB    = DATA_WIDTH / 32;
    localparam int BEAT_W = beat_idx_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [31:0]           word_dout_q, word_dout_d;
    logic [BEAT_W-1:0]     word_beat;
    int                    word_off;

    always_comb begin
        word_beat = BEAT_W'(int'(word_idx) / WPB);
        word_off  = int'(word_idx) % WPB;
    end

    assign beat_rdata = mem_q[beat_idx];
    assign word_dout  = word_dout_q;

    // The engine never enables both write ports together; beat writes win
    // anyway so a stray word write can never corrupt an incoming read beat.
    always_comb begin
        mem_d = mem_q;
        if (beat_we) begin
            mem_d[beat_idx] = beat_wdata;
        end else if (word_wr) begin
            mem_d[word_beat][word_off*32 +: 32] = word_din;
        end
    end

    // Reading from mem_q gives the pre-write value on a same-word read/write.
    always_comb begin
        word_dout_d = word_dout_q;
        if (word_rd) begin
            word_dout_d = mem_q[word_beat][word_off*32 +: 32];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            word_dout_q <= '0;
        end else begin
            mem_q       <= mem_d;
            word_dout_q <= word_dout_d;
        end
    end

endmodule

// File: rtl/ddr_burst_engine.sv
// ---------------------------------------------------------------------------
// ddr_burst_engine
// Moves bursts of 1..MAX_BURST beats between the local beat buffer and the
// DDR controller local_* interface, in the phy_clk domain.
// Ports:
//   phy_clk, rst_n (async active-low)          clock / reset
//   local_*                                    DDR controller request side
//   cmd_valid/cmd_ready/cmd_op/cmd_addr/len    command handshake
//   done, status                               completion pulse, status word
//   buf_wr/buf_rd/buf_idx/buf_din/buf_dout     32-bit buffer word access
// ---------------------------------------------------------------------------
module ddr_burst_engine
    import ddr_eng_pkg::*;
#(
    parameter int DDR_ADDR_WIDTH = 26,
    parameter int DDR_DATA_WIDTH = 128,
    parameter int MAX_BURST      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                               phy_clk,
    input  logic                                               rst_n,
    input  logic                                               local_init_done,
    output logic [DDR_ADDR_WIDTH-1:0]                          local_address,
    output logic [$clog2(MAX_BURST):0]                         local_size,
    output logic                                               local_burstbegin,
    input  logic                                               local_ready,
    output logic                                               local_read_req,
    output logic                                               local_write_req,
    output logic [DDR_DATA_WIDTH-1:0]                          local_wdata,
    input  logic [DDR_DATA_WIDTH-1:0]                          local_rdata,
    input  logic                                               local_rdata_valid,
    input  logic                                               cmd_valid,
    output logic                                               cmd_ready,
    input  logic                                               cmd_op,
    input  logic [DDR_ADDR_WIDTH-1:0]                          cmd_addr,
    input  logic [$clog2(MAX_BURST):0]                         cmd_len,
    output logic                                               done,
    output logic [31:0]                                        status,
    input  logic                                               buf_wr,
    input  logic                                               buf_rd,
    input  logic [$clog2(MAX_BURST*DDR_DATA_WIDTH/32)-1:0]     buf_idx,
    input  logic [31:0]                                        buf_din,
    output logic [31:0]                                        buf_dout
);

    localparam int LEN_W  = $clog2(MAX_BURST) + 1;
    localparam int BEAT_W = beat_idx_width(MAX_BURST);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    state_e                    state_q, state_d;
    op_e                       op_q, op_d;
    logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          beat_cnt_q, beat_cnt_d;
    logic [TO_W-1:0]           to_cnt_q, to_cnt_d;
    logic                      done_q, done_d;
    logic                      done_flag_q, done_flag_d;
    logic                      timeout_err_q, timeout_err_d;
    logic                      len_err_q, len_err_d;
    logic                      buf_conflict_q, buf_conflict_d;

    logic                      busy;
    logic                      accept;
    logic                      len_ok;
    logic                      last_beat;
    logic                      rd_capture;
    logic                      to_expired;
    logic [DDR_DATA_WIDTH-1:0] beat_rdata;

    assign busy       = (state_q == WR_BURST) || (state_q == RD_REQ) || (state_q == RD_DATA);
    assign accept     = (state_q == IDLE) && cmd_valid;
    assign len_ok     = (cmd_len != '0) && (cmd_len <= LEN_W'(MAX_BURST));
    assign last_beat  = (beat_cnt_q + LEN_W'(1)) == len_q;
    assign to_expired = to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1);
    // Beats are only taken while a read is in flight and still owed.
    assign rd_capture = ((state_q == RD_REQ) || (state_q == RD_DATA)) &&
                        local_rdata_valid && (beat_cnt_q < len_q);

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // A read can finish while still in RD_REQ when a single-beat burst's data
    // arrives together with the request being accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT:     if (local_init_done) state_d = IDLE;
            IDLE:     if (accept && len_ok) state_d = (op_e'(cmd_op) == OP_LOAD) ? RD_REQ : WR_BURST;
            WR_BURST: if (local_ready && last_beat) state_d = IDLE;
            RD_REQ: begin
                if (rd_capture && last_beat) state_d = IDLE;
                else if (local_ready)        state_d = RD_DATA;
            end
            RD_DATA:  if ((rd_capture && last_beat) || to_expired) state_d = IDLE;
            default:  state_d = INIT;
        endcase
    end

    always_comb begin
        cmd_ready        = 1'b0;
        local_read_req   = 1'b0;
        local_write_req  = 1'b0;
        local_burstbegin = 1'b0;
        local_address    = '0;
        local_size       = '0;
        local_wdata      = '0;
        case (state_q)
            IDLE: cmd_ready = 1'b1;
            WR_BURST: begin
                local_write_req  = 1'b1;
                local_burstbegin = (beat_cnt_q == '0);
                local_address    = addr_q;
                local_size       = len_q;
                local_wdata      = beat_rdata;
            end
            RD_REQ: begin
                local_read_req   = 1'b1;
                local_burstbegin = 1'b1;
                local_address    = addr_q;
                local_size       = len_q;
            end
            default: ;
        endcase
    end

    // Command latching, beat/timeout counting and the sticky status flags.
    // A completing beat in the final timeout cycle counts as success.
    always_comb begin
        op_d           = op_q;
        addr_d         = addr_q;
        len_d          = len_q;
        beat_cnt_d     = beat_cnt_q;
        to_cnt_d       = to_cnt_q;
        done_d         = 1'b0;
        done_flag_d    = done_flag_q;
        timeout_err_d  = timeout_err_q;
        len_err_d      = len_err_q;
        buf_conflict_d = buf_conflict_q;

        if (accept) begin
            op_d          = op_e'(cmd_op);
            addr_d        = cmd_addr;
            len_d         = cmd_len;
            beat_cnt_d    = '0;
            done_flag_d   = 1'b0;
            timeout_err_d = 1'b0;
            if (len_ok) begin
                len_err_d      = 1'b0;
                buf_conflict_d = 1'b0;
            end else begin
                len_err_d   = 1'b1;
                done_d      = 1'b1;
                done_flag_d = 1'b1;
            end
        end

        if (busy && buf_wr) begin
            buf_conflict_d = 1'b1;
        end

        if ((state_q == WR_BURST && local_ready) || rd_capture) begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
            if (last_beat) begin
                done_d      = 1'b1;
                done_flag_d = 1'b1;
            end
        end

        if (state_q == RD_REQ && local_ready) begin
            to_cnt_d = '0;
        end

        if (state_q == RD_DATA) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            if (to_expired && !(rd_capture && last_beat)) begin
                timeout_err_d = 1'b1;
                done_d        = 1'b1;
                done_flag_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q           <= OP_STORE;
            addr_q         <= '0;
            len_q          <= '0;
            beat_cnt_q     <= '0;
            to_cnt_q       <= '0;
            done_q         <= 1'b0;
            done_flag_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
            len_err_q      <= 1'b0;
            buf_conflict_q <= 1'b0;
        end else begin
            op_q           <= op_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            beat_cnt_q     <= beat_cnt_d;
            to_cnt_q       <= to_cnt_d;
            done_q         <= done_d;
            done_flag_q    <= done_flag_d;
            timeout_err_q  <= timeout_err_d;
            len_err_q      <= len_err_d;
            buf_conflict_q <= buf_conflict_d;
        end
    end

    assign done = done_q;

    always_comb begin
        status                                    = '0;
        status[STAT_STATE_LSB +: 3]               = state_q;
        status[STAT_BUSY]                         = busy;
        status[STAT_DONE]                         = done_flag_q;
        status[STAT_TIMEOUT]                      = timeout_err_q;
        status[STAT_LEN_ERR]                      = len_err_q;
        status[STAT_BUF_CONFLICT]                 = buf_conflict_q;
        status[STAT_BEATS_LSB +: STAT_BEATS_W]    = STAT_BEATS_W'(beat_cnt_q);
    end

    // Word writes are dropped while a burst owns the buffer.
    ddr_beat_buffer #(
        .DATA_WIDTH (DDR_DATA_WIDTH),
        .DEPTH      (MAX_BURST)
    ) u_beat_buffer (
        .clk        (phy_clk),
        .rst_n      (rst_n),
        .word_wr    (buf_wr && !busy),
        .word_rd    (buf_rd),
        .word_idx   (buf_idx),
        .word_din   (buf_din),
        .word_dout  (buf_dout),
        .beat_idx   (beat_cnt_q[BEAT_W-1:0]),
        .beat_rdata (beat_rdata),
        .beat_we    (rd_capture),
        .beat_wdata (local_rdata)
    );

endmodule

// File: doc/ddr_burst_engine.md
Name: ddr_burst_engine

Overview:
- Single-clock, parametrised successor to the single-beat DDR PHY read/write controller.
- Moves bursts of 1..MAX_BURST beats between a local beat buffer and the DDR controller local_* interface.
- Adds burst length, a ready/valid command handshake, read timeout, error status and word-granular buffer access.
- Sits in the phy_clk domain. Any SoC-clock crossing is handled by a separate wrapper.

Parameters:
- DDR_ADDR_WIDTH, 26, local_address width.
- DDR_DATA_WIDTH, 128, beat width; must be a multiple of 32.
- MAX_BURST, 8, maximum beats per command; power of 2, at least 1.
- TIMEOUT_CYCLES, 1024, maximum phy_clk cycles to wait for all read beats.

Ports:
- phy_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- local_init_done  in  1  controller calibration done
- local_address  out  DDR_ADDR_WIDTH  burst start address
- local_size  out  $clog2(MAX_BURST)+1  burst count
- local_burstbegin  out  1  first-beat marker
- local_ready  in  1  controller accepts the current request or beat
- local_read_req  out  1  read request
- local_write_req  out  1  write request
- local_wdata  out  DDR_DATA_WIDTH  write beat
- local_rdata  in  DDR_DATA_WIDTH  read beat
- local_rdata_valid  in  1  read beat valid
- cmd_valid  in  1  command valid
- cmd_ready  out  1  engine accepts a command
- cmd_op  in  1  0 = STORE (buffer to DDR), 1 = LOAD (DDR to buffer)
- cmd_addr  in  DDR_ADDR_WIDTH  start address
- cmd_len  in  $clog2(MAX_BURST)+1  beat count
- done  out  1  one-cycle pulse on command completion
- status  out  32  status word
- buf_wr  in  1  buffer word write
- buf_rd  in  1  buffer word read
- buf_idx  in  $clog2(MAX_BURST*DDR_DATA_WIDTH/32)  word index
- buf_din  in  32  write data
- buf_dout  out  32  read data, registered

Behaviour:
- Reset values: local_* outputs 0, cmd_ready 0, done 0, status 0, buf_dout 0, buffer contents 0, state INIT.
- Reset mid-burst aborts the burst immediately; no outstanding-beat tracking survives reset.
- States: INIT, IDLE, WR_BURST, RD_REQ, RD_DATA.
- INIT -> IDLE when local_init_done=1. cmd_ready=1 only in IDLE.
- Command accept (IDLE, cmd_valid=1):
  - cmd_addr, cmd_len and cmd_op are latched.
  - Sticky flags done_flag and timeout_err are cleared.
  - cmd_len=0 or cmd_len>MAX_BURST: state stays IDLE, len_err is set, done pulses the next cycle, no local_* activity.
- WR_BURST:
  - local_write_req=1.
  - local_wdata = buffer beat[beat_cnt].
  - local_burstbegin=1 while beat_cnt=0.
  - local_size = latched length; local_address = latched address.
  - Beat advances only when local_ready=1. Signals are held stable while local_ready=0.
  - Last beat accepted -> IDLE, done pulses.
- RD_REQ:
  - local_read_req=1 and local_burstbegin=1, held until local_ready=1, then -> RD_DATA.
  - An rdata_valid beat arriving in the same cycle as local_ready is captured.
- RD_DATA:
  - Each local_rdata_valid writes beat[beat_cnt] and increments beat_cnt.
  - Last beat -> IDLE, done pulses the cycle after the last beat.
  - Timeout counter starts at RD_REQ acceptance. Reaching TIMEOUT_CYCLES -> IDLE, timeout_err set, done pulses, partial beats are retained.
  - local_rdata_valid outside RD_REQ/RD_DATA is ignored.
- Buffer access:
  - buf_rd: buf_dout updated 1 cycle later with word buf_idx; word 0 = beat0[31:0].
  - buf_wr in IDLE/INIT writes word buf_idx.
  - buf_wr while busy is dropped and sets buf_conflict.
  - buf_rd while busy is allowed.
  - Simultaneous buf_wr and buf_rd to the same word: buf_dout returns the old value.
- status:
  - [2:0] state encoding; [3] busy (not IDLE/INIT).
  - [4] done_flag; [5] timeout_err; [6] len_err; [7] buf_conflict.
  - [15:8] beats transferred on the last command; [31:16] 0.
  - len_err and buf_conflict clear on the next valid command accept.

Decomposition:
- Package ddr_eng_pkg holds:
  - state enum (INIT=0, IDLE=1, WR_BURST=2, RD_REQ=3, RD_DATA=4);
  - op enum (OP_STORE=0, OP_LOAD=1);
  - status bit-position constants.
- Sub-module ddr_beat_buffer: MAX_BURST x DDR_DATA_WIDTH storage with a 32-bit word port (registered read) and a full-beat port (combinational read, single-cycle write). The engine FSM and counters stay in the top.

Test Plan:
- Init gating: local_init_done held 0 for 20 cycles, cmd_valid=1 -> cmd_ready=0, no local_* activity. Drive init_done=1 -> status[2:0]=1, cmd_ready=1.
- Store burst: write 16 words 0x0..0xF with MAX_BURST=8, issue STORE addr=0x100 len=4 with local_ready low on alternate cycles -> 4 write beats, beat0 = {0x3,0x2,0x1,0x0}, burstbegin only on beat0, done pulse, status[15:8]=4.
- Load burst: LOAD addr=0x200 len=3, rdata beats A/B/C with a 2-cycle gap -> buffer words 0..11 = A,B,C; buf_rd idx=4 returns B[31:0] one cycle later.
- Read timeout: TIMEOUT_CYCLES=16, LOAD len=2, deliver only 1 beat -> IDLE after 16 cycles, status[5]=1, status[15:8]=1, one done pulse.
- Length error and conflict: LOAD len=0 -> status[6]=1, no local_read_req. buf_wr during WR_BURST -> word unchanged, status[7]=1.
- Reset mid-burst: assert rst_n=0 during beat 2 of an 8-beat store -> all outputs 0 asynchronously. After release, INIT then IDLE.
